block_carry_expand_pipe: RTL and testbench

//  Back end of the tree-adder datapath, downstream of the group-generate/propagate

---
 rtl/tree_adder_pkg.sv | 21 ++
 rtl/carry_expand_cell.sv | 21 ++
 rtl/group_gp_cell.sv | 21 ++
 rtl/block_carry_expand_pipe.sv | 135 +++++++++++++
 tb/tb_block_carry_expand_pipe.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/tree_adder_pkg.sv
// Shared definitions for the tree-adder back end: block count, the
// WIDTH/CELL_WIDTH legality check, and a stage-valid record.
package tree_adder_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int CELL_WIDTH_DEF = 4;
    localparam int NB             = WIDTH_DEF / CELL_WIDTH_DEF;

    // True when the operand width splits into whole blocks of CELL_WIDTH bits
    function automatic bit width_ok(input int w, input int c);
        return (c >= 1) && (w >= c) && ((w % c) == 0);
    endfunction

    // Occupancy of the three pipeline stages
    typedef struct packed {
        logic v1;
        logic v2;
        logic v3;
    } stage_valid_t;

endpackage

// File: rtl/carry_expand_cell.sv
// Carry expansion cell: given the carry into a block, recover every
// per-bit carry of that block (inverse of the group cell).
module carry_expand_cell #(
    parameter int CELL_WIDTH = 4
) (
    input  logic                  i_c_in,
    input  logic [CELL_WIDTH-1:0] i_g,
    input  logic [CELL_WIDTH-1:0] i_p,
    output logic [CELL_WIDTH:0]   o_c
);

    // c[0] is the block carry-in; each next carry follows g | p&c
    always_comb begin
        o_c    = '0;
        o_c[0] = i_c_in;
        for (int i = 0; i < CELL_WIDTH; i++) begin
            o_c[i+1] = i_g[i] | (i_p[i] & o_c[i]);
        end
    end

endmodule

// File: rtl/group_gp_cell.sv
// Group cell: reduces per-bit g/p of one block to block generate/propagate.
module group_gp_cell #(
    parameter int CELL_WIDTH = 4
) (
    input  logic [CELL_WIDTH-1:0] i_g,
    input  logic [CELL_WIDTH-1:0] i_p,
    output logic                  o_gg,
    output logic                  o_gp
);

    // Ripple the group terms from LSB upward; g dominates when g=p=1
    always_comb begin
        o_gg = 1'b0;
        o_gp = 1'b1;
        for (int i = 0; i < CELL_WIDTH; i++) begin
            o_gg = i_g[i] | (i_p[i] & o_gg);
            o_gp = o_gp & i_p[i];
        end
    end

endmodule

// File: rtl/block_carry_expand_pipe.sv
// Tree-adder back end: S1 block g/p reduction, S2 block carry resolution,
// S3 per-bit carry expansion and sum/cout. Valid/ready at both ends with a
// combinational ready chain so a full pipe still moves one operand per cycle.
module block_carry_expand_pipe
    import tree_adder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CELL_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NBLK = WIDTH / CELL_WIDTH;

    if (!width_ok(WIDTH, CELL_WIDTH)) begin : g_bad_width
        $error("block_carry_expand_pipe: WIDTH must be a positive multiple of CELL_WIDTH");
    end

    stage_valid_t r_vld;

    // stage-1 registers
    logic [NBLK-1:0]  r1_gg, r1_gp;
    logic [WIDTH-1:0] r1_g, r1_p;
    logic             r1_cin;
    // stage-2 registers
    logic [NBLK:0]    r2_c;
    logic [WIDTH-1:0] r2_g, r2_p;

    logic             w_rdy2, w_rdy3;
    logic [NBLK-1:0]  w_gg, w_gp;
    logic [NBLK:0]    w_blk_c;
    logic [NBLK-1:0][CELL_WIDTH:0] w_cell_c;
    logic [WIDTH-1:0] w_sum;

    // A stage may load when it is empty or its successor takes its content
    assign w_rdy3   = !r_vld.v3 | out_ready;
    assign w_rdy2   = !r_vld.v2 | w_rdy3;
    assign in_ready = !r_vld.v1 | w_rdy2;
    assign out_valid = r_vld.v3;

    // S1 combinational: block generate/propagate from the raw bits
    for (genvar k = 0; k < NBLK; k++) begin : g_grp
        group_gp_cell #(.CELL_WIDTH(CELL_WIDTH)) u_grp (
            .i_g  (in_g[k*CELL_WIDTH +: CELL_WIDTH]),
            .i_p  (in_p[k*CELL_WIDTH +: CELL_WIDTH]),
            .o_gg (w_gg[k]),
            .o_gp (w_gp[k])
        );
    end

    // S2 combinational: ripple the carry across blocks
    always_comb begin
        w_blk_c    = '0;
        w_blk_c[0] = r1_cin;
        for (int k = 0; k < NBLK; k++) begin
            w_blk_c[k+1] = r1_gg[k] | (r1_gp[k] & w_blk_c[k]);
        end
    end

    // S3 combinational: expand each block carry back to per-bit carries
    for (genvar k = 0; k < NBLK; k++) begin : g_exp
        carry_expand_cell #(.CELL_WIDTH(CELL_WIDTH)) u_exp (
            .i_c_in (r2_c[k]),
            .i_g    (r2_g[k*CELL_WIDTH +: CELL_WIDTH]),
            .i_p    (r2_p[k*CELL_WIDTH +: CELL_WIDTH]),
            .o_c    (w_cell_c[k])
        );
        assign w_sum[k*CELL_WIDTH +: CELL_WIDTH] =
            r2_p[k*CELL_WIDTH +: CELL_WIDTH] ^ w_cell_c[k][CELL_WIDTH-1:0];
    end

    // Stage 1: capture operand and its block g/p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld.v1 <= 1'b0;
            r1_gg    <= '0;
            r1_gp    <= '0;
            r1_g     <= '0;
            r1_p     <= '0;
            r1_cin   <= 1'b0;
        end else if (in_ready) begin
            r_vld.v1 <= in_valid;
            if (in_valid) begin
                r1_gg  <= w_gg;
                r1_gp  <= w_gp;
                r1_g   <= in_g;
                r1_p   <= in_p;
                r1_cin <= in_cin;
            end
        end
    end

    // Stage 2: register resolved block carries, forward raw g/p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld.v2 <= 1'b0;
            r2_c     <= '0;
            r2_g     <= '0;
            r2_p     <= '0;
        end else if (w_rdy2) begin
            r_vld.v2 <= r_vld.v1;
            if (r_vld.v1) begin
                r2_c <= w_blk_c;
                r2_g <= r1_g;
                r2_p <= r1_p;
            end
        end
    end

    // Stage 3: register sum/cout; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld.v3 <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (w_rdy3) begin
            r_vld.v3 <= r_vld.v2;
            if (r_vld.v2) begin
                out_sum  <= w_sum;
                out_cout <= w_cell_c[NBLK-1][CELL_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_block_carry_expand_pipe.sv
// Randomized bench for block_carry_expand_pipe; reference is plain a+b+cin.
module tb_block_carry_expand_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_g = '0, in_p = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;

    block_carry_expand_pipe #(.WIDTH(W), .CELL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_g(in_g), .in_p(in_p), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_acc = 0, n_emit = 0;
    bit both_seen = 1'b0;
    logic [W:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: present inputs after the falling edge, then observe the
    // transfers that the next rising edge will perform.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic ordy);
        logic acc, emit;
        @(negedge clk);
        in_valid  = v;
        in_g      = a & b;
        in_p      = a ^ b;
        in_cin    = cin;
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        emit = out_valid & out_ready;
        if (emit) begin
            n_emit++;
            chk("emit_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("sum_cout", {15'b0, out_cout, out_sum}, {15'b0, exp_q.pop_front()});
        end
        if (acc) begin
            n_acc++;
            exp_q.push_back({1'b0, a} + {1'b0, b} + {16'b0, cin});
        end
        if (acc && emit) both_seen = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, held;
        int acc0, emit0;

        // reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_sum", {16'b0, out_sum}, 0);
        chk("rst_out_cout", {31'b0, out_cout}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        @(negedge clk); rst_n = 1'b1;

        // full propagate: g=0, p=FFFF, cin=1
        cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("prop_sum", {16'b0, out_sum}, 32'h0000);
        chk("prop_cout", {31'b0, out_cout}, 1);
        drain(10);

        // latency: output valid three edges after the capturing edge
        cycle(1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat_e1", {31'b0, out_valid}, 0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat_e2", {31'b0, out_valid}, 0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat_e3", {31'b0, out_valid}, 1);
        chk("ex2_sum", {16'b0, out_sum}, 32'h2143);
        chk("ex2_cout", {31'b0, out_cout}, 0);
        drain(10);

        // 100 back-to-back operands
        acc0 = n_acc; emit0 = n_emit;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        chk("b2b_accepts", n_acc - acc0, 100);
        drain(10);
        chk("b2b_emits", n_emit - emit0, 100);

        // stall: consumer blocked for 5 cycles while feeding
        acc0 = n_acc; emit0 = n_emit;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            if (i == 3) held = out_sum;
        end
        chk("stall_accepts", n_acc - acc0, 3);
        chk("stall_in_ready", {31'b0, in_ready}, 0);
        chk("stall_out_valid", {31'b0, out_valid}, 1);
        chk("stall_held", {16'b0, out_sum}, {16'b0, held});
        drain(10);
        chk("stall_emits", n_emit - emit0, 3);

        // reset with two operands in flight
        cycle(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_out_sum", {16'b0, out_sum}, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        emit0 = n_emit;
        drain(10);
        chk("post_rst_emits", n_emit - emit0, 1);

        // random valid/ready toggling
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ((i & 63) == 0) begin ra = 16'hFFFF; rb = 16'h0000; end
            cycle(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        drain(20);
        chk("same_cycle_accept_emit", {31'b0, both_seen}, 1);
        chk("total_balance", n_emit, n_acc - 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
